pulse_param_loader: RTL and testbench

- Upstream neighbour of the pulse sequencer: turns the PC byte stream into the sequencer's parameter bus.
- Consumes bytes from the UART receiver (rx_data/rx_valid) on the 50 MHz clock domain.
- Frames, checksums and unpacks a fixed-layout parameter packet.
- On a good frame, updates all parameter outputs atomically in one cycle and pulses rx_done.

---
 rtl/pulse_param_loader_pkg.sv | 61 ++++++
 rtl/pulse_param_loader.sv | 199 +++++++++++++++++++
 tb/tb_pulse_param_loader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_param_loader_pkg.sv
// Shared definitions for the PC->sequencer parameter frame: framing constants,
// field offsets inside the 224-bit payload shadow, reset defaults and FSM states.
package pulse_param_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF      = 8'hA5;
  localparam int         FRAME_PAYLOAD_LEN  = 28;
  localparam int         SHADOW_W           = 8 * FRAME_PAYLOAD_LEN;
  localparam int         TIMEOUT_CYCLES_DEF = 500000;
  localparam int         TIMER_W            = 20;

  // LSB positions of each field; the first payload byte lands in the top byte.
  localparam int OFF_PER     = 192;
  localparam int OFF_P1WID   = 176;
  localparam int OFF_DEL     = 160;
  localparam int OFF_P2WID   = 144;
  localparam int OFF_P1WID2  = 128;
  localparam int OFF_DEL2    = 112;
  localparam int OFF_P2WID2  = 96;
  localparam int OFF_P1ST2   = 80;
  localparam int OFF_NUT_W   = 72;
  localparam int OFF_NUT_D   = 56;
  localparam int OFF_PR_ATT  = 48;
  localparam int OFF_PO_ATT  = 40;
  localparam int OFF_CP      = 32;
  localparam int OFF_P_BL    = 24;
  localparam int OFF_P_BL_HF = 8;
  localparam int OFF_BL      = 0;

  localparam int DEFAULT_PER   = 4000;
  localparam int DEFAULT_P1WID = 30;
  localparam int DEFAULT_P2WID = 60;
  localparam int DEFAULT_DEL   = 200;
  localparam int DEFAULT_P_BL  = 100;
  localparam int DEFAULT_CP    = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] per;
    logic [15:0] p1wid;
    logic [15:0] del;
    logic [15:0] p2wid;
    logic [15:0] p1wid2;
    logic [15:0] del2;
    logic [15:0] p2wid2;
    logic [15:0] p1st2;
    logic [7:0]  nut_w;
    logic [15:0] nut_d;
    logic [6:0]  pr_att;
    logic [6:0]  po_att;
    logic [7:0]  cp;
    logic [7:0]  p_bl;
    logic [15:0] p_bl_hf;
    logic        bl;
  } params_t;

endpackage

// File: rtl/pulse_param_loader.sv
// Frames, checksums and unpacks the PC parameter packet from the UART byte
// stream; all parameter outputs update together on a good frame.
module pulse_param_loader
  import pulse_param_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned DEF_PER        = DEFAULT_PER,
  parameter int unsigned DEF_P1WID      = DEFAULT_P1WID,
  parameter int unsigned DEF_P2WID      = DEFAULT_P2WID,
  parameter int unsigned DEF_DEL        = DEFAULT_DEL,
  parameter int unsigned DEF_P_BL       = DEFAULT_P_BL,
  parameter int unsigned DEF_CP         = DEFAULT_CP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] per,
  output logic [15:0] p1wid,
  output logic [15:0] del,
  output logic [15:0] p2wid,
  output logic [15:0] p1wid2,
  output logic [15:0] del2,
  output logic [15:0] p2wid2,
  output logic [15:0] p1st2,
  output logic [7:0]  nut_w,
  output logic [15:0] nut_d,
  output logic [6:0]  pr_att,
  output logic [6:0]  po_att,
  output logic [7:0]  cp,
  output logic [7:0]  p_bl,
  output logic [15:0] p_bl_hf,
  output logic        bl,
  output logic        rx_done,
  output logic        frame_err,
  output logic        busy
);

  localparam params_t RESET_PARAMS = '{
    per:     32'(DEF_PER),
    p1wid:   16'(DEF_P1WID),
    del:     16'(DEF_DEL),
    p2wid:   16'(DEF_P2WID),
    p1wid2:  16'd0,
    del2:    16'd0,
    p2wid2:  16'd0,
    p1st2:   16'd0,
    nut_w:   8'd0,
    nut_d:   16'd0,
    pr_att:  7'd0,
    po_att:  7'd0,
    cp:      8'(DEF_CP),
    p_bl:    8'(DEF_P_BL),
    p_bl_hf: 16'(DEF_P_BL / 2),
    bl:      1'b1
  };
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]         LAST_INDEX   = 5'(FRAME_PAYLOAD_LEN - 1);

  state_e                state_q, state_d;
  logic [SHADOW_W-1:0]   shadow_q, shadow_d;
  logic [7:0]            sum_q, sum_d;
  logic [4:0]            index_q, index_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  params_t               params_q, params_d;
  logic                  rx_done_q, rx_done_d;
  logic                  frame_err_q, frame_err_d;
  params_t               shadow_params;
  logic                  timeout_hit;
  logic                  unused_shadow_bits;

  // Attenuator bit 7 and the upper seven bits of the bl byte carry no meaning.
  always_comb begin
    shadow_params         = '0;
    shadow_params.per     = shadow_q[OFF_PER +: 32];
    shadow_params.p1wid   = shadow_q[OFF_P1WID +: 16];
    shadow_params.del     = shadow_q[OFF_DEL +: 16];
    shadow_params.p2wid   = shadow_q[OFF_P2WID +: 16];
    shadow_params.p1wid2  = shadow_q[OFF_P1WID2 +: 16];
    shadow_params.del2    = shadow_q[OFF_DEL2 +: 16];
    shadow_params.p2wid2  = shadow_q[OFF_P2WID2 +: 16];
    shadow_params.p1st2   = shadow_q[OFF_P1ST2 +: 16];
    shadow_params.nut_w   = shadow_q[OFF_NUT_W +: 8];
    shadow_params.nut_d   = shadow_q[OFF_NUT_D +: 16];
    shadow_params.pr_att  = shadow_q[OFF_PR_ATT +: 7];
    shadow_params.po_att  = shadow_q[OFF_PO_ATT +: 7];
    shadow_params.cp      = shadow_q[OFF_CP +: 8];
    shadow_params.p_bl    = shadow_q[OFF_P_BL +: 8];
    shadow_params.p_bl_hf = shadow_q[OFF_P_BL_HF +: 16];
    shadow_params.bl      = shadow_q[OFF_BL];
  end

  assign unused_shadow_bits = ^{shadow_q[OFF_PR_ATT + 7], shadow_q[OFF_PO_ATT + 7],
                                shadow_q[OFF_BL + 1 +: 7]};

  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign timeout_hit = (state_q != IDLE) && !rx_valid && (timer_q == TIMEOUT_LAST);

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    sum_d       = sum_q;
    index_d     = index_q;
    timer_d     = timer_q;
    params_d    = params_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    if (state_q != IDLE && !rx_valid && timer_q != '1) begin
      timer_d = timer_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = PAYLOAD;
          index_d = '0;
          sum_d   = '0;
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          shadow_d = {shadow_q[SHADOW_W-9:0], rx_data};
          sum_d    = sum_q + rx_data;
          timer_d  = '0;
          if (index_q == LAST_INDEX) begin
            state_d = CHECK;
          end else begin
            index_d = index_q + 5'd1;
          end
        end else if (timeout_hit) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      CHECK: begin
        if (rx_valid) begin
          timer_d = '0;
          state_d = IDLE;
          if (rx_data == sum_q) begin
            params_d  = shadow_params;
            rx_done_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (timeout_hit) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      sum_q       <= '0;
      index_q     <= '0;
      timer_q     <= '0;
      params_q    <= RESET_PARAMS;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      sum_q       <= sum_d;
      index_q     <= index_d;
      timer_q     <= timer_d;
      params_q    <= params_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign per       = params_q.per;
  assign p1wid     = params_q.p1wid;
  assign del       = params_q.del;
  assign p2wid     = params_q.p2wid;
  assign p1wid2    = params_q.p1wid2;
  assign del2      = params_q.del2;
  assign p2wid2    = params_q.p2wid2;
  assign p1st2     = params_q.p1st2;
  assign nut_w     = params_q.nut_w;
  assign nut_d     = params_q.nut_d;
  assign pr_att    = params_q.pr_att;
  assign po_att    = params_q.po_att;
  assign cp        = params_q.cp;
  assign p_bl      = params_q.p_bl;
  assign p_bl_hf   = params_q.p_bl_hf;
  assign bl        = params_q.bl;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_pulse_param_loader.sv
// Bench for pulse_param_loader: table of whole frames plus hand-written
// timeout and reset-abort sequences, with a scoreboard on rx_done commits.
module tb_pulse_param_loader;
  import pulse_param_loader_pkg::*;

  localparam int TB_TIMEOUT = 100;
  localparam int PW = $bits(params_t);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [31:0] per;
  logic [15:0] p1wid, del, p2wid, p1wid2, del2, p2wid2, p1st2, nut_d, p_bl_hf;
  logic [7:0]  nut_w, cp, p_bl;
  logic [6:0]  pr_att, po_att;
  logic        bl, rx_done, frame_err, busy;

  pulse_param_loader #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid), .p1wid2(p1wid2),
    .del2(del2), .p2wid2(p2wid2), .p1st2(p1st2), .nut_w(nut_w), .nut_d(nut_d),
    .pr_att(pr_att), .po_att(po_att), .cp(cp), .p_bl(p_bl), .p_bl_hf(p_bl_hf),
    .bl(bl), .rx_done(rx_done), .frame_err(frame_err), .busy(busy)
  );

  // Clock / watchdog
  always #10 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [PW-1:0] exp_q[$];

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic params_t get_out();
    params_t p;
    p = '{per: per, p1wid: p1wid, del: del, p2wid: p2wid, p1wid2: p1wid2,
          del2: del2, p2wid2: p2wid2, p1st2: p1st2, nut_w: nut_w, nut_d: nut_d,
          pr_att: pr_att, po_att: po_att, cp: cp, p_bl: p_bl, p_bl_hf: p_bl_hf, bl: bl};
    return p;
  endfunction

  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_rx_done", PW'(1), PW'(0));
      end else begin
        check("commit_params", PW'(get_out()), exp_q.pop_front());
      end
    end
    if (frame_err) err_cnt++;
  end

  // Driver tasks
  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_sync_and_payload(input logic [SHADOW_W-1:0] payload, input int nbytes,
                                       input int gap, output logic [7:0] sum);
    logic [7:0] b;
    sum = 8'h00;
    send_byte(SYNC_BYTE_DEF, gap);
    for (int i = 0; i < nbytes; i++) begin
      b = payload[SHADOW_W-1-8*i -: 8];
      sum = sum + b;
      send_byte(b, gap);
    end
  endtask

  // Vector table
  typedef struct {
    string               name;
    logic [SHADOW_W-1:0] payload;
    logic                bad_csum;
    logic                garbage;
    int                  gap;
    params_t             exp;
  } vec_t;

  vec_t vecs[4];
  params_t def_p, last_good;
  logic [7:0] sum;
  int err_before, done_before, exp_err;

  initial begin
    def_p = '{per: 32'd4000, p1wid: 16'd30, del: 16'd200, p2wid: 16'd60, p1wid2: 16'd0,
              del2: 16'd0, p2wid2: 16'd0, p1st2: 16'd0, nut_w: 8'd0, nut_d: 16'd0,
              pr_att: 7'd0, po_att: 7'd0, cp: 8'd1, p_bl: 8'd100, p_bl_hf: 16'd50, bl: 1'b1};

    vecs[0].name = "frame_a";
    vecs[0].payload = {32'h00001F40, 16'h0011, 16'h0222, 16'h0033, 16'h0044, 16'h0555,
                       16'h0066, 16'h0777, 8'h12, 16'h0345, 8'h85, 8'hFF, 8'h03, 8'h40,
                       16'h0020, 8'hFE};
    vecs[0].bad_csum = 1'b0; vecs[0].garbage = 1'b0; vecs[0].gap = 3;
    vecs[0].exp = '{per: 32'd8000, p1wid: 16'h0011, del: 16'h0222, p2wid: 16'h0033,
                    p1wid2: 16'h0044, del2: 16'h0555, p2wid2: 16'h0066, p1st2: 16'h0777,
                    nut_w: 8'h12, nut_d: 16'h0345, pr_att: 7'h05, po_att: 7'h7F,
                    cp: 8'd3, p_bl: 8'h40, p_bl_hf: 16'h0020, bl: 1'b0};

    vecs[1] = vecs[0];
    vecs[1].name = "frame_a_bad_csum";
    vecs[1].bad_csum = 1'b1;

    vecs[2].name = "frame_b";
    vecs[2].payload = {32'h12345678, 16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0102, 16'h0304,
                       16'h0506, 16'h0708, 8'h9A, 16'hBCDE, 8'h7F, 8'h80, 8'hFF, 8'h01,
                       16'hFFFF, 8'h01};
    vecs[2].bad_csum = 1'b0; vecs[2].garbage = 1'b0; vecs[2].gap = 0;
    vecs[2].exp = '{per: 32'h12345678, p1wid: 16'hA1B2, del: 16'hC3D4, p2wid: 16'hE5F6,
                    p1wid2: 16'h0102, del2: 16'h0304, p2wid2: 16'h0506, p1st2: 16'h0708,
                    nut_w: 8'h9A, nut_d: 16'hBCDE, pr_att: 7'h7F, po_att: 7'h00,
                    cp: 8'hFF, p_bl: 8'h01, p_bl_hf: 16'hFFFF, bl: 1'b1};

    vecs[3].name = "frame_c_inner_sync";
    vecs[3].payload = {32'hA5A50001, 16'h00A5, 16'hA500, 16'h1234, 16'h00A5, 16'h0001,
                       16'h0002, 16'h0003, 8'hA5, 16'hA5A5, 8'hA5, 8'h25, 8'h07, 8'hA5,
                       16'h0052, 8'hA5};
    vecs[3].bad_csum = 1'b0; vecs[3].garbage = 1'b1; vecs[3].gap = 1;
    vecs[3].exp = '{per: 32'hA5A50001, p1wid: 16'h00A5, del: 16'hA500, p2wid: 16'h1234,
                    p1wid2: 16'h00A5, del2: 16'h0001, p2wid2: 16'h0002, p1st2: 16'h0003,
                    nut_w: 8'hA5, nut_d: 16'hA5A5, pr_att: 7'h25, po_att: 7'h25,
                    cp: 8'h07, p_bl: 8'hA5, p_bl_hf: 16'h0052, bl: 1'b1};

    exp_err = 0;

    // Reset then idle
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_params", PW'(get_out()), PW'(def_p));
    check("reset_busy", PW'(busy), PW'(0));
    check("reset_strobes", PW'({rx_done, frame_err}), PW'(0));
    repeat (100) @(negedge clk);
    check("idle_params", PW'(get_out()), PW'(def_p));
    check("idle_no_rx_done", PW'(done_cnt), PW'(0));
    last_good = def_p;

    // Table of whole frames
    for (int v = 0; v < 4; v++) begin
      if (vecs[v].garbage) begin
        send_byte(8'h00, 2);
        send_byte(8'hFF, 2);
        check({vecs[v].name, "_garbage_busy"}, PW'(busy), PW'(0));
      end
      send_sync_and_payload(vecs[v].payload, FRAME_PAYLOAD_LEN, vecs[v].gap, sum);
      check({vecs[v].name, "_busy_before_csum"}, PW'(busy), PW'(1));
      check({vecs[v].name, "_params_before_csum"}, PW'(get_out()), PW'(last_good));
      if (!vecs[v].bad_csum) exp_q.push_back(PW'(vecs[v].exp));
      else exp_err++;
      send_byte(vecs[v].bad_csum ? sum + 8'd1 : sum, 0);
      check({vecs[v].name, "_rx_done"}, PW'(rx_done), PW'(!vecs[v].bad_csum));
      check({vecs[v].name, "_frame_err"}, PW'(frame_err), PW'(vecs[v].bad_csum));
      check({vecs[v].name, "_busy_after"}, PW'(busy), PW'(0));
      if (!vecs[v].bad_csum) last_good = vecs[v].exp;
      check({vecs[v].name, "_params"}, PW'(get_out()), PW'(last_good));
      @(negedge clk);
      check({vecs[v].name, "_strobes_drop"}, PW'({rx_done, frame_err}), PW'(0));
    end

    // Timeout after 10 payload bytes
    send_sync_and_payload(vecs[2].payload, 10, 0, sum);
    repeat (TB_TIMEOUT - 1) @(negedge clk);
    check("timeout_not_yet", PW'({busy, frame_err}), PW'(2'b10));
    @(negedge clk);
    exp_err++;
    check("timeout_frame_err", PW'({busy, frame_err}), PW'(2'b01));
    check("timeout_params", PW'(get_out()), PW'(last_good));
    @(negedge clk);
    check("timeout_err_drop", PW'(frame_err), PW'(0));
    send_sync_and_payload(vecs[2].payload, FRAME_PAYLOAD_LEN, 2, sum);
    exp_q.push_back(PW'(vecs[2].exp));
    send_byte(sum, 0);
    check("after_timeout_rx_done", PW'(rx_done), PW'(1));
    last_good = vecs[2].exp;
    @(negedge clk);

    // Reset during payload byte 15
    err_before = err_cnt;
    done_before = done_cnt;
    send_sync_and_payload(vecs[0].payload, 15, 1, sum);
    check("abort_busy_mid_frame", PW'(busy), PW'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_params_default", PW'(get_out()), PW'(def_p));
    check("abort_busy", PW'(busy), PW'(0));
    repeat (TB_TIMEOUT + 20) @(negedge clk);
    check("abort_no_strobes", PW'({32'(done_cnt - done_before), 32'(err_cnt - err_before)}), PW'(0));
    check("abort_params_hold", PW'(get_out()), PW'(def_p));

    // Final report
    check("frame_err_count", PW'(err_cnt), PW'(exp_err));
    check("scoreboard_drained", PW'(exp_q.size()), PW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
